// File: rtl/jtframe_prog_pkg.sv
// Shared types for the ROM download path: FIFO entry layout, loader FSM states
// and SDRAM byte-lane masks.
package jtframe_prog_pkg;

  typedef struct packed {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [1:0]  mask;
    logic [7:0]  data;
  } prog_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MASK_LO = 2'b10;
  localparam logic [1:0] MASK_HI = 2'b01;

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Small synchronous FIFO with a combinational head. A push while full is only
// accepted together with a pop in the same cycle.
module jtframe_prog_fifo #(
  parameter int W  = 34,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jtframe_prog_loader.sv
// Converts the HPS byte download stream into SDRAM byte-lane writes, diverting
// the file header and holding dwnld_busy until the FIFO has fully drained.
module jtframe_prog_loader
  import jtframe_prog_pkg::*;
#(
  parameter int          HEADER    = 0,
  parameter logic [21:0] BA1_START = 22'h10_0000,
  parameter logic [21:0] BA2_START = 22'h20_0000,
  parameter logic [21:0] BA3_START = 22'h30_0000,
  parameter int          FIFO_AW   = 2
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             downloading,
  input  logic [21:0]      ioctl_addr,
  input  logic [7:0]       ioctl_data,
  input  logic             ioctl_wr,
  input  logic             prog_rdy,
  output logic [21:0]      prog_addr,
  output logic [1:0]       prog_ba,
  output logic [7:0]       prog_data,
  output logic [1:0]       prog_mask,
  output logic             prog_we,
  output logic [7:0]       header_addr,
  output logic [7:0]       header_data,
  output logic             header_wr,
  output logic             dwnld_busy,
  output logic             dwnld_done,
  output logic             overflow,
  output state_t           state,
  output logic [FIFO_AW:0] fifo_count
);

  localparam logic [22:0] HDR_LEN = 23'(HEADER);

  // Handshake: prog_* is valid while prog_we is high and holds until a cycle in
  // which prog_rdy is high; that cycle is the transfer and pops the FIFO head.

  state_t      state_nx;
  logic        dl_q;
  logic        dl_rise;
  logic        dl_fall;
  logic        in_load;
  logic        hdr_hit;
  logic        pay_hit;
  logic        push;
  logic        pop;
  logic        drop;
  logic        full;
  logic        empty;
  logic        drained;
  logic [21:0] offset;
  logic [21:0] base;
  logic [21:0] rel;
  prog_entry_t entry;
  prog_entry_t head;

  assign dl_rise = downloading & ~dl_q;
  assign dl_fall = ~downloading & dl_q;
  assign in_load = (state == LOAD);
  assign hdr_hit = in_load & ioctl_wr & ({1'b0, ioctl_addr} < HDR_LEN);
  assign pay_hit = in_load & ioctl_wr & ~hdr_hit;

  // Region mapping: banks 1..3 are addressed relative to their own start offset.
  always_comb begin
    offset = ioctl_addr - HDR_LEN[21:0];
    entry  = '0;
    base   = '0;
    if (offset >= BA3_START) begin
      entry.ba = 2'd3;
      base     = BA3_START;
    end else if (offset >= BA2_START) begin
      entry.ba = 2'd2;
      base     = BA2_START;
    end else if (offset >= BA1_START) begin
      entry.ba = 2'd1;
      base     = BA1_START;
    end
    rel        = offset - base;
    entry.addr = {1'b0, rel[21:1]};
    entry.mask = offset[0] ? MASK_HI : MASK_LO;
    entry.data = ioctl_data;
  end

  assign pop  = prog_we & prog_rdy;
  assign push = pay_hit & (~full | pop);
  assign drop = pay_hit & full & ~pop;

  jtframe_prog_fifo #(
    .W  ($bits(prog_entry_t)),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk_sys),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign prog_we   = ~empty;
  assign prog_ba   = empty ? 2'd0  : head.ba;
  assign prog_addr = empty ? 22'd0 : head.addr;
  assign prog_mask = empty ? 2'd0  : head.mask;
  assign prog_data = empty ? 8'd0  : head.data;

  // Looking through the pop lets dwnld_done follow the final pop by one cycle.
  assign drained = empty | (pop & (fifo_count == (FIFO_AW+1)'(1)));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (dl_rise) state_nx = LOAD;
      LOAD:    if (dl_fall) state_nx = DRAIN;
      DRAIN: begin
        if (dl_rise)      state_nx = LOAD;
        else if (drained) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign dwnld_busy = (state == LOAD) | (state == DRAIN);
  assign dwnld_done = (state == DONE);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state       <= IDLE;
      dl_q        <= 1'b0;
      overflow    <= 1'b0;
      header_wr   <= 1'b0;
      header_addr <= '0;
      header_data <= '0;
    end else begin
      state     <= state_nx;
      dl_q      <= downloading;
      header_wr <= hdr_hit;
      if (hdr_hit) begin
        header_addr <= ioctl_addr[7:0];
        header_data <= ioctl_data;
      end
      if (state == IDLE && dl_rise) overflow <= 1'b0;
      else if (drop)                overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtframe_prog_loader.sv
// Bench for jtframe_prog_loader: two instances (HEADER=0 and HEADER=4) share
// one stimulus stream; each has its own expected queue of SDRAM writes.
module tb_jtframe_prog_loader;
  import jtframe_prog_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [21:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic        prog_rdy = 1'b0;

  logic [21:0] p0_addr, p4_addr;
  logic [1:0]  p0_ba, p4_ba, p0_mask, p4_mask;
  logic [7:0]  p0_data, p4_data;
  logic        p0_we, p4_we;
  logic [7:0]  h0_addr, h0_data, h4_addr, h4_data;
  logic        h0_wr, h4_wr;
  logic        busy0, busy4, done0, done4, ovf0, ovf4;
  state_t      st0, st4;
  logic [2:0]  cnt0, cnt4;

  logic [33:0] exp0_q[$];
  logic [33:0] exp4_q[$];
  logic [15:0] hexp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int hdr_cnt = 0;
  int done_cnt0 = 0;
  int done_cnt4 = 0;

  always #5 clk = ~clk;

  jtframe_prog_loader #(.HEADER(0)) u0 (
    .clk_sys(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_rdy(prog_rdy), .prog_addr(p0_addr), .prog_ba(p0_ba),
    .prog_data(p0_data), .prog_mask(p0_mask), .prog_we(p0_we),
    .header_addr(h0_addr), .header_data(h0_data), .header_wr(h0_wr),
    .dwnld_busy(busy0), .dwnld_done(done0), .overflow(ovf0),
    .state(st0), .fifo_count(cnt0)
  );

  jtframe_prog_loader #(.HEADER(4)) u4 (
    .clk_sys(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_rdy(prog_rdy), .prog_addr(p4_addr), .prog_ba(p4_ba),
    .prog_data(p4_data), .prog_mask(p4_mask), .prog_we(p4_we),
    .header_addr(h4_addr), .header_data(h4_data), .header_wr(h4_wr),
    .dwnld_busy(busy4), .dwnld_done(done4), .overflow(ovf4),
    .state(st4), .fifo_count(cnt4)
  );

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference mapping written from the file-offset view of the bank layout.
  function automatic logic [33:0] model(input logic [21:0] a, input logic [7:0] d, input int hdr);
    int o;
    int base;
    logic [1:0] ba;
    logic [21:0] wa;
    logic [1:0] mk;
    o = (int'(a) - hdr) & 32'h3F_FFFF;
    if (o >= 32'h30_0000)      begin ba = 2'd3; base = 32'h30_0000; end
    else if (o >= 32'h20_0000) begin ba = 2'd2; base = 32'h20_0000; end
    else if (o >= 32'h10_0000) begin ba = 2'd1; base = 32'h10_0000; end
    else                       begin ba = 2'd0; base = 0; end
    wa = 22'((o - base) / 2);
    mk = (o % 2 == 1) ? 2'b01 : 2'b10;
    return {ba, wa, mk, d};
  endfunction

  task automatic wr_byte(input logic [21:0] a, input logic [7:0] d, input bit acc);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    if (acc) begin
      exp0_q.push_back(model(a, d, 0));
      if (a < 22'd4) hexp_q.push_back({a[7:0], d});
      else           exp4_q.push_back(model(a, d, 4));
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (p0_we && prog_rdy) begin
        if (exp0_q.size() == 0) check("u0 unexpected write", 34'd1, 34'd0);
        else check("u0 write", {p0_ba, p0_addr, p0_mask, p0_data}, exp0_q.pop_front());
      end
      if (p4_we && prog_rdy) begin
        if (exp4_q.size() == 0) check("u4 unexpected write", 34'd1, 34'd0);
        else check("u4 write", {p4_ba, p4_addr, p4_mask, p4_data}, exp4_q.pop_front());
      end
      if (h4_wr) begin
        hdr_cnt++;
        if (hexp_q.size() == 0) check("u4 unexpected header", 34'd1, 34'd0);
        else check("u4 header", 34'({h4_addr, h4_data}), 34'(hexp_q.pop_front()));
      end
      if (h0_wr) check("u0 header strobe", 34'd1, 34'd0);
      if (done0) done_cnt0++;
      if (done4) done_cnt4++;
    end
  end

  initial begin
    // Reset values
    repeat (3) tick();
    check("rst prog_we", 34'({p0_we, p4_we}), 34'd0);
    check("rst prog fields", 34'({p4_ba, p4_addr, p4_mask, p4_data}), 34'd0);
    check("rst header", 34'({h4_wr, h4_addr, h4_data}), 34'd0);
    check("rst flags", 34'({busy0, done0, ovf0, busy4, done4, ovf4}), 34'd0);
    check("rst state", 34'(st0), 34'(IDLE));

    rst = 1'b0;
    downloading = 1'b1;
    tick();
    check("load state", 34'({st0, st4}), 34'({LOAD, LOAD}));
    check("load busy", 34'({busy0, busy4}), 34'b11);

    // Header split
    prog_rdy = 1'b1;
    for (int i = 0; i < 6; i++) wr_byte(22'(i), 8'($urandom_range(0, 255)), 1'b1);
    repeat (3) tick();
    check("header pulses", 34'(hdr_cnt), 34'd4);
    check("header queue drained", 34'({exp0_q.size(), exp4_q.size(), hexp_q.size()}), 34'd0);

    // Bank crossing
    prog_rdy = 1'b0;
    wr_byte(22'h10_0003, 8'hA5, 1'b1);
    check("bank1 u0", {p0_we, p0_ba, p0_addr, p0_mask}, {1'b1, 2'd1, 22'd1, 2'b01});
    check("bank1 u4", {p4_we, p4_ba, p4_addr, p4_mask}, {1'b1, 2'd0, 22'h7_FFFF, 2'b01});
    tick();
    check("stall hold u0", {p0_we, p0_ba, p0_addr, p0_mask}, {1'b1, 2'd1, 22'd1, 2'b01});
    prog_rdy = 1'b1;
    tick();
    prog_rdy = 1'b0;
    wr_byte(22'h0F_FFFF, 8'h3C, 1'b1);
    check("bank0 top u0", {p0_ba, p0_addr, p0_mask}, {2'd0, 22'h7_FFFF, 2'b01});
    prog_rdy = 1'b1;
    tick();

    // Random addresses across all banks, full throughput
    for (int i = 0; i < 10; i++)
      wr_byte(22'($urandom_range(4, 32'h3F_FFFF)), 8'($urandom_range(0, 255)), 1'b1);
    repeat (2) tick();
    check("random queue drained", 34'(exp0_q.size() + exp4_q.size()), 34'd0);

    // Stall and overflow: fifth byte is dropped
    prog_rdy = 1'b0;
    for (int i = 0; i < 5; i++) wr_byte(22'(16 + i), 8'(8'h50 + i), i < 4);
    check("overflow set", 34'({ovf0, ovf4}), 34'b11);
    check("full count", 34'(cnt0), 34'd4);
    prog_rdy = 1'b1;
    repeat (6) tick();
    check("overflow drained", 34'({cnt0, cnt4, p0_we}), 34'd0);
    check("overflow queue", 34'(exp0_q.size() + exp4_q.size()), 34'd0);
    check("overflow sticky", 34'({ovf0, ovf4}), 34'b11);

    // Drain and done with prog_rdy toggling
    prog_rdy = 1'b0;
    for (int i = 0; i < 3; i++) wr_byte(22'(32 + i), 8'($urandom_range(0, 255)), 1'b1);
    downloading = 1'b0;
    tick();
    check("drain state", 34'(st0), 34'(DRAIN));
    for (int i = 0; i < 3; i++) begin
      check("drain busy", 34'({busy0, done0, busy4, done4}), 34'b1010);
      prog_rdy = 1'b1;
      tick();
      prog_rdy = 1'b0;
      if (i < 2) tick();
    end
    check("done after last pop", 34'({busy0, done0, busy4, done4}), 34'b0101);
    tick();
    check("idle after done", 34'({st0, st4, done0}), 34'({IDLE, IDLE, 1'b0}));
    check("done pulse count", 34'({done_cnt0[7:0], done_cnt4[7:0]}), 34'({8'd1, 8'd1}));

    // Simultaneous push and pop while full
    downloading = 1'b1;
    tick();
    check("reload clears overflow", 34'({ovf0, ovf4, st0}), 34'({2'b00, LOAD}));
    prog_rdy = 1'b0;
    for (int i = 0; i < 4; i++) wr_byte(22'(64 + i), 8'($urandom_range(0, 255)), 1'b1);
    check("full before push/pop", 34'(cnt4), 34'd4);
    prog_rdy = 1'b1;
    wr_byte(22'd68, 8'hE7, 1'b1);
    check("push/pop count", 34'({cnt0, cnt4}), 34'({3'd4, 3'd4}));
    check("push/pop no overflow", 34'({ovf0, ovf4}), 34'd0);
    repeat (6) tick();
    check("push/pop drained", 34'(exp0_q.size() + exp4_q.size()), 34'd0);

    // Reset mid-drain
    prog_rdy = 1'b0;
    for (int i = 0; i < 2; i++) wr_byte(22'(80 + i), 8'($urandom_range(0, 255)), 1'b1);
    downloading = 1'b0;
    tick();
    check("pre-reset drain", 34'({st0, cnt0}), 34'({DRAIN, 3'd2}));
    rst = 1'b1;
    tick();
    check("reset prog_we", 34'({p0_we, p4_we}), 34'd0);
    check("reset state", 34'({st0, st4}), 34'({IDLE, IDLE}));
    check("reset busy/done", 34'({busy0, done0, busy4, done4}), 34'd0);
    check("reset header regs", 34'({h4_addr, h4_data}), 34'd0);
    exp0_q.delete();
    exp4_q.delete();
    rst = 1'b0;
    repeat (4) tick();
    check("no done after reset", 34'({done_cnt0[7:0], done_cnt4[7:0]}), 34'({8'd1, 8'd1}));
    check("idle after reset", 34'({st0, p0_we}), 34'({IDLE, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jtframe_prog_loader.md
# jtframe_prog_loader

Sits between the HPS ROM download port and the SDRAM programming port of the board wrapper. Turns the byte stream from `ioctl_addr`/`ioctl_data`/`ioctl_wr` into SDRAM byte-lane writes on `prog_addr`/`prog_data`/`prog_mask`/`prog_we`. It strips a file header, maps file regions onto SDRAM banks, and buffers bursts in a small FIFO while the controller stalls. It also keeps `dwnld_busy` high until every byte is committed, so the game reset is not released while the FIFO is still draining.

## Interface
Parameters:
- `HEADER`, 0: number of leading file bytes diverted to the header port instead of SDRAM.
- `BA1_START`, 22'h10_0000: first byte offset (after header) that maps to bank 1.
- `BA2_START`, 22'h20_0000: first byte offset that maps to bank 2.
- `BA3_START`, 22'h30_0000: first byte offset that maps to bank 3.
- `FIFO_AW`, 2: FIFO address width; depth is 2**FIFO_AW.

Ports:
- `clk_sys`  in  1  system clock; all logic runs on it.
- `rst`  in  1  synchronous, active-high reset.
- `downloading`  in  1  download window from hps_io.
- `ioctl_addr`  in  22  byte address within the file.
- `ioctl_data`  in  8  byte value.
- `ioctl_wr`  in  1  one-cycle byte strobe.
- `prog_rdy`  in  1  controller accepts the presented write this cycle.
- `prog_addr`  out  22  word address inside the bank.
- `prog_ba`  out  2  SDRAM bank.
- `prog_data`  out  8  byte value; the controller replicates it on both lanes.
- `prog_mask`  out  2  active-low lane mask: 2'b10 writes the low byte, 2'b01 writes the high byte.
- `prog_we`  out  1  write request, held until accepted.
- `header_addr`  out  8  header byte index.
- `header_data`  out  8  header byte value.
- `header_wr`  out  1  one-cycle header strobe.
- `dwnld_busy`  out  1  high in LOAD and DRAIN.
- `dwnld_done`  out  1  one-cycle pulse when the last byte is committed.
- `overflow`  out  1  sticky; a byte was dropped because the FIFO was full.

## Operation
- **Header path.** When `ioctl_wr` is high and `ioctl_addr < HEADER`:
  - pulse `header_wr` with `header_addr = ioctl_addr[7:0]` and the byte on `header_data`;
  - the byte does not enter the FIFO.
- **Payload path.** Define offset `o = ioctl_addr - HEADER` (22-bit).
  - Bank select: `ba` = 3 if `o >= BA3_START`, else 2 if `o >= BA2_START`, else 1 if `o >= BA1_START`, else 0.
  - Bank base `base` = 0 for bank 0, otherwise the matching `BAn_START`.
  - Word address: `(o - base) >> 1`, zero-extended to 22 bits.
  - Lane mask: `o[0] = 0` gives 2'b10; `o[0] = 1` gives 2'b01.
  - The entry `{ba, addr, mask, data}` is pushed into the FIFO.
- **FIFO full.** If the FIFO is full on a payload strobe, the byte is dropped and `overflow` is set.
- **FIFO head.** The head entry drives the `prog_*` outputs, and `prog_we = !empty`. The entry is popped on `prog_we & prog_rdy`. A push and a pop in the same cycle leave the count unchanged; this is legal when full.
- **State machine:**
  - IDLE -> LOAD on `downloading` rising; this also clears `overflow`.
  - LOAD -> DRAIN on `downloading` falling.
  - DRAIN -> DONE when the FIFO is empty.
  - DONE -> IDLE unconditionally on the next cycle. `dwnld_done` is high only in DONE.
  - DRAIN -> LOAD if `downloading` rises again; the FIFO contents are kept and `overflow` is not cleared.
  - `ioctl_wr` outside LOAD is ignored.
- **Reset outputs.** `rst` (synchronous) empties the FIFO and forces IDLE; an in-flight write is abandoned. Values during and after reset:
  - all strobes are 0;
  - `prog_*` and `header_*` are 0;
  - `overflow` is 0.

## Timing
- `ioctl_wr` at cycle n with an empty FIFO: the entry is registered at edge n+1 and `prog_we` is high during cycle n+1.
- `header_wr` is registered and pulses at cycle n+1.
- With `prog_rdy` held high, throughput is one byte per cycle.
- `prog_we` and the `prog_*` fields stay stable until the cycle in which `prog_rdy` is sampled high.
- The next entry appears on the cycle after the pop.
- `downloading` is edge-detected with one register: LOAD is entered one cycle after the rise.
- `dwnld_done` fires exactly one cycle after the pop that empties the FIFO in DRAIN.
- If the FIFO is already empty when DRAIN is entered, DRAIN lasts one cycle before DONE.

## Structure
- Package `jtframe_prog_pkg`:
  - `typedef prog_entry_t {ba, addr, mask, data}`, 34 bits;
  - `typedef enum {IDLE, LOAD, DRAIN, DONE}`;
  - localparams `MASK_LO = 2'b10`, `MASK_HI = 2'b01`.
- Sub-module `jtframe_prog_fifo`: synchronous FIFO parameterised by width and `FIFO_AW`, with push, pop, full, empty and head outputs.
- The top holds the FSM, the header path and the address mapping.

## Test plan
- **Header split.** `HEADER = 4`, bytes at file addresses 0..5 with `prog_rdy = 1`:
  - `header_wr` pulses 4 times, with addresses 0..3;
  - then `prog_addr` = 0, 0 and `prog_mask` = 2'b10, 2'b01, both with `prog_ba` = 0.
- **Bank crossing.** `HEADER = 0`, byte at 22'h10_0003:
  - `prog_ba = 1`, `prog_addr = 1`, `prog_mask = 2'b01`.
  - A byte at 22'h0F_FFFF gives `prog_ba = 0`, `prog_addr = 22'h7_FFFF`.
- **Stall and overflow.** `prog_rdy = 0`, 5 strobes into a depth-4 FIFO:
  - `overflow = 1` and the FIFO holds 4 entries;
  - after releasing `prog_rdy`, exactly the first 4 bytes come out, in order.
- **Drain and done.** `downloading` falls with 3 entries queued and `prog_rdy` toggling 1/0:
  - `dwnld_busy` stays high until the third pop;
  - `dwnld_done` pulses once, 1 cycle after that pop.
- **Simultaneous push/pop.** FIFO full, strobe with `prog_rdy = 1` in the same cycle:
  - no overflow, count stays 4, order is preserved.
- **Reset mid-drain.** `rst` asserted in DRAIN with 2 entries queued:
  - on the next cycle `prog_we = 0`, state is IDLE, `dwnld_busy = 0`, and no `dwnld_done` pulse occurs.
